ysyx_22041211_alu_arbiter: RTL and testbench
============================================

# ysyx_22041211_alu_arbiter

Sequencer that shares one combinational ALU (4-bit `alu_control` op, `src1`/`src2` operands, `result`/`alu_less_o`/`alu_zero_o` outputs) between two requesters, e.g. EXU (port 0) and a CSR/branch helper (port 1). It arbitrates valid/ready requests, registers operands into the ALU, captures the ALU outputs one cycle later and returns them over a per-port response handshake. The block sits between the requesters and the single shared ALU instance.

## Interface
Parameters:
- `DATA_LEN`, 32, operand/result width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `req0_valid_i` / `req1_valid_i`  in  1  request valid, held until accepted.
- `req0_ready_o` / `req1_ready_o`  out  1  request accepted this cycle.
- `req0_src1_i`, `req0_src2_i` / `req1_src1_i`, `req1_src2_i`  in  DATA_LEN  operands.
- `req0_op_i` / `req1_op_i`  in  4  ALU op code (`ALU_OP_*` encoding).
- `rsp0_valid_o` / `rsp1_valid_o`  out  1  response valid.
- `rsp0_ready_i` / `rsp1_ready_i`  in  1  response consumed.
- `rsp_result_o`  out  DATA_LEN  captured ALU result (shared by both ports).
- `rsp_less_o`, `rsp_zero_o`  out  1  captured less/zero flags.
- `alu_src1_o`, `alu_src2_o`  out  DATA_LEN  to ALU `src1`/`src2`.
- `alu_control_o`  out  4  to ALU `alu_control`.
- `alu_result_i`  in  DATA_LEN  from ALU `result`.
- `alu_less_i`, `alu_zero_i`  in  1  from ALU `alu_less_o`, `alu_zero_o`.

## Operation
- FSM states: IDLE, EXEC, RESP; reset state IDLE.
- IDLE: if either `reqN_valid_i` is high, grant one port (see Configuration); assert that port's `reqN_ready_o` combinationally in the same cycle; on the edge latch its src1/src2/op into the operand registers, record `grant_id`, and go to EXEC. With no valid request, stay in IDLE.
- `reqN_ready_o` is 0 in EXEC and RESP, and is 0 for the non-granted port.
- EXEC: operand registers drive `alu_*_o`. On the edge capture `alu_result_i`/`alu_less_i`/`alu_zero_i` into the response registers and go to RESP. Unconditional, one cycle.
- RESP: `rsp{grant_id}_valid_o`=1, other port 0. On `rsp{grant_id}_ready_i`=1 go to IDLE. Otherwise hold, with result and flags stable.
- The `rspN_ready_i` of the non-granted port is ignored.
- Operand registers hold their last value outside EXEC. The ALU never sees a combinational path from the request inputs.
- Reset asserted in any state: go to IDLE immediately. Any in-flight request is dropped and no response is issued.

## Timing
- Reset values: `req*_ready_o`=0, `rsp*_valid_o`=0, `rsp_result_o`=0, `rsp_less_o`=0, `rsp_zero_o`=0, `alu_src1_o`=0, `alu_src2_o`=0, `alu_control_o`=0, `grant_id`=0, `last_grant`=1.
- Accept at edge T, with ready&valid high in the cycle before T.
- Operands are on the ALU during cycle T..T+1. The response is valid from T+1 (after the EXEC edge) until consumed.
- Minimum spacing between accepts: 3 cycles (IDLE→EXEC→RESP→IDLE). The cycle after a response handshake is IDLE and can accept.
- Widths: there is no arithmetic inside the block. The ALU values pass through unmodified at DATA_LEN bits.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration. When both ports are valid in IDLE, grant the port ≠ `last_grant`; `last_grant` updates on each accept. With reset `last_grant`=1, port 0 wins the first tie. With a single valid port, that port is granted regardless of `last_grant`.
- Not defined: fixed priority, where port 0 always wins. `last_grant` is absent and port 1 can starve.

## Test plan
- Port 0 ADD 5+3, rsp0_ready=1 → req0_ready high 1 cycle, rsp0_valid at accept+1, rsp_result=8, rsp_zero=0, rsp1_valid stays 0.
- Port 1 SUB 7−7 → rsp_result=0, rsp_zero=1. Port 1 SLTU 1 vs 0xFFFFFFFF → rsp_result=1, rsp_less=1.
- Both ports valid and held for 2 ops each, with `ALU_ARB_RR_EN` → grants alternate 0,1,0,1. Without the macro → 0,0, then 1,1 once req0 drops.
- rsp0_ready held low 4 cycles in RESP → rsp0_valid and result stable all 4 cycles, req0/req1_ready stay 0, and the next accept occurs 1 cycle after the handshake.
- rst_n pulsed low during EXEC → all outputs go to 0 immediately, no response after release, and a fresh req0 is accepted normally.

Source files
------------

// File: rtl/ysyx_22041211_alu_arbiter.sv
// Shares one combinational ALU between two requesters: IDLE grants and latches operands, EXEC captures the ALU outputs, RESP returns them.
// Optional ALU_ARB_RR_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module ysyx_22041211_alu_arbiter #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic [DATA_LEN-1:0] req0_src1_i,
    input  logic [DATA_LEN-1:0] req0_src2_i,
    input  logic [3:0]          req0_op_i,
    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    input  logic [DATA_LEN-1:0] req1_src1_i,
    input  logic [DATA_LEN-1:0] req1_src2_i,
    input  logic [3:0]          req1_op_i,
    output logic                rsp0_valid_o,
    input  logic                rsp0_ready_i,
    output logic                rsp1_valid_o,
    input  logic                rsp1_ready_i,
    output logic [DATA_LEN-1:0] rsp_result_o,
    output logic                rsp_less_o,
    output logic                rsp_zero_o,
    output logic [DATA_LEN-1:0] alu_src1_o,
    output logic [DATA_LEN-1:0] alu_src2_o,
    output logic [3:0]          alu_control_o,
    input  logic [DATA_LEN-1:0] alu_result_i,
    input  logic                alu_less_i,
    input  logic                alu_zero_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q;
    logic [DATA_LEN-1:0] src1_q;
    logic [DATA_LEN-1:0] src2_q;
    logic [3:0]          op_q;
    logic [DATA_LEN-1:0] result_q;
    logic                less_q;
    logic                zero_q;
    logic                grant_id_q;
    logic                rsp0_valid_q;
    logic                rsp1_valid_q;

    logic any_valid;
    logic grant_sel;
    logic accept;
    logic rsp_ready_sel;

`ifdef ALU_ARB_RR_EN
    logic last_grant_q;

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant_sel = req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant_sel = ~last_grant_q;
        end
    end
`else
    assign grant_sel = ~req0_valid_i;
`endif

    assign any_valid     = req0_valid_i | req1_valid_i;
    assign accept        = (state_q == IDLE) && any_valid;
    // Gated by rst_n so ready reads 0 while reset is held even with a valid pending.
    assign req0_ready_o  = rst_n && accept && !grant_sel;
    assign req1_ready_o  = rst_n && accept &&  grant_sel;
    assign rsp_ready_sel = grant_id_q ? rsp1_ready_i : rsp0_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src1_q       <= '0;
            src2_q       <= '0;
            op_q         <= '0;
            result_q     <= '0;
            less_q       <= 1'b0;
            zero_q       <= 1'b0;
            grant_id_q   <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        src1_q     <= grant_sel ? req1_src1_i : req0_src1_i;
                        src2_q     <= grant_sel ? req1_src2_i : req0_src2_i;
                        op_q       <= grant_sel ? req1_op_i   : req0_op_i;
                        grant_id_q <= grant_sel;
`ifdef ALU_ARB_RR_EN
                        last_grant_q <= grant_sel;
`endif
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    result_q     <= alu_result_i;
                    less_q       <= alu_less_i;
                    zero_q       <= alu_zero_i;
                    rsp0_valid_q <= ~grant_id_q;
                    rsp1_valid_q <= grant_id_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready_sel) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_src1_o    = src1_q;
    assign alu_src2_o    = src2_q;
    assign alu_control_o = op_q;
    assign rsp_result_o  = result_q;
    assign rsp_less_o    = less_q;
    assign rsp_zero_o    = zero_q;
    assign rsp0_valid_o  = rsp0_valid_q;
    assign rsp1_valid_o  = rsp1_valid_q;

endmodule

// File: tb/tb_ysyx_22041211_alu_arbiter.sv
// Scoreboard bench for ysyx_22041211_alu_arbiter; the bench also plays the shared ALU.
module tb_ysyx_22041211_alu_arbiter;

    localparam int DW = 32;
    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_SLT  = 4'd2;
    localparam logic [3:0] ALU_OP_SLTU = 4'd3;
    localparam logic [3:0] ALU_OP_XOR  = 4'd4;
    localparam logic [3:0] ALU_OP_AND  = 4'd7;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          less;
        logic          zero;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
    logic [3:0]    req0_op = '0, req1_op = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_rdy = 1'b1, rsp1_rdy = 1'b1;
    logic [DW-1:0] rsp_result;
    logic          rsp_less, rsp_zero;
    logic [DW-1:0] alu_src1, alu_src2;
    logic [3:0]    alu_control;
    rsp_t          alu_now;

    rsp_t sb0[$];
    rsp_t sb1[$];
    int   order_log[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    function automatic rsp_t alu_ref(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        rsp_t r;
        case (op)
            ALU_OP_ADD:  r.res = a + b;
            ALU_OP_SUB:  r.res = a - b;
            ALU_OP_SLT:  r.res = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_OP_SLTU: r.res = {{(DW-1){1'b0}}, a < b};
            ALU_OP_XOR:  r.res = a ^ b;
            ALU_OP_AND:  r.res = a & b;
            default:     r.res = '0;
        endcase
        r.less = (op == ALU_OP_SLTU) ? (a < b) : ($signed(a) < $signed(b));
        r.zero = (r.res == '0);
        return r;
    endfunction

    assign alu_now = alu_ref(alu_control, alu_src1, alu_src2);

    ysyx_22041211_alu_arbiter #(.DATA_LEN(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid_i  (req0_valid),
        .req0_ready_o  (req0_ready),
        .req0_src1_i   (req0_src1),
        .req0_src2_i   (req0_src2),
        .req0_op_i     (req0_op),
        .req1_valid_i  (req1_valid),
        .req1_ready_o  (req1_ready),
        .req1_src1_i   (req1_src1),
        .req1_src2_i   (req1_src2),
        .req1_op_i     (req1_op),
        .rsp0_valid_o  (rsp0_valid),
        .rsp0_ready_i  (rsp0_rdy),
        .rsp1_valid_o  (rsp1_valid),
        .rsp1_ready_i  (rsp1_rdy),
        .rsp_result_o  (rsp_result),
        .rsp_less_o    (rsp_less),
        .rsp_zero_o    (rsp_zero),
        .alu_src1_o    (alu_src1),
        .alu_src2_o    (alu_src2),
        .alu_control_o (alu_control),
        .alu_result_i  (alu_now.res),
        .alu_less_i    (alu_now.less),
        .alu_zero_i    (alu_now.zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Response monitor: pops the per-port scoreboard on each response handshake.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n) begin
            if (rsp0_valid) begin
                if (sb0.size() == 0) begin
                    check("rsp0_unexpected", rsp0_valid, 0);
                end else if (rsp0_rdy) begin
                    e = sb0.pop_front();
                    check("rsp0_result", rsp_result, e.res);
                    check("rsp0_less", rsp_less, e.less);
                    check("rsp0_zero", rsp_zero, e.zero);
                    check("rsp0_excl", rsp1_valid, 0);
                    order_log.push_back(0);
                end
            end
            if (rsp1_valid) begin
                if (sb1.size() == 0) begin
                    check("rsp1_unexpected", rsp1_valid, 0);
                end else if (rsp1_rdy) begin
                    e = sb1.pop_front();
                    check("rsp1_result", rsp_result, e.res);
                    check("rsp1_less", rsp_less, e.less);
                    check("rsp1_zero", rsp_zero, e.zero);
                    check("rsp1_excl", rsp0_valid, 0);
                    order_log.push_back(1);
                end
            end
        end
    end

    // Drives one request, holds valid until ready is seen, drops valid just after the accept edge.
    task automatic issue(input int p, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input bit expect_rsp);
        bit acc = 1'b0;
        if (expect_rsp) begin
            if (p == 0) sb0.push_back(alu_ref(op, a, b));
            else        sb1.push_back(alu_ref(op, a, b));
        end
        if (p == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_src1 = a; req0_src2 = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_src1 = a; req1_src2 = b;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
                acc = 1'b1;
                break;
            end
        end
        check((p == 0) ? "req0_accept" : "req1_accept", acc, 1);
        @(posedge clk);
        #1;
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb0.size() == 0 && sb1.size() == 0) break;
        end
        check("sb0_drained", sb0.size(), 0);
        check("sb1_drained", sb1.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rsp_t exp_bp;
        int   exp_order[4];

        // Reset values, including ready held low with a valid pending.
        req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rsp0", rsp0_valid, 0);
        check("rst_rsp1", rsp1_valid, 0);
        check("rst_result", rsp_result, 0);
        check("rst_less", rsp_less, 0);
        check("rst_zero", rsp_zero, 0);
        check("rst_src1", alu_src1, 0);
        check("rst_src2", alu_src2, 0);
        check("rst_ctrl", alu_control, 0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Port 0 ADD 5+3 with latency and ALU-drive checks.
        issue(0, ALU_OP_ADD, 32'd5, 32'd3, 1);
        @(negedge clk);
        check("exec_rsp0_low", rsp0_valid, 0);
        check("exec_src1", alu_src1, 5);
        check("exec_src2", alu_src2, 3);
        check("exec_ctrl", alu_control, ALU_OP_ADD);
        check("exec_ready0", req0_ready, 0);
        @(negedge clk);
        check("resp_rsp0_high", rsp0_valid, 1);
        check("resp_rsp1_low", rsp1_valid, 0);
        drain();

        // Port 1 zero and unsigned-less cases.
        issue(1, ALU_OP_SUB, 32'd7, 32'd7, 1);
        drain();
        issue(1, ALU_OP_SLTU, 32'd1, 32'hFFFF_FFFF, 1);
        drain();
        issue(1, ALU_OP_SLT, 32'hFFFF_FFFE, 32'd3, 1);
        drain();

        // Both ports held valid for two ops each.
        order_log.delete();
        fork
            begin
                issue(0, ALU_OP_ADD, 32'd10, 32'd20, 1);
                issue(0, ALU_OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 1);
            end
            begin
                issue(1, ALU_OP_SUB, 32'd100, 32'd1, 1);
                issue(1, ALU_OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
            end
        join
        drain();
`ifdef ALU_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 1, 1};
`endif
        check("order_len", order_log.size(), 4);
        for (int i = 0; i < 4 && i < order_log.size(); i++) begin
            check("grant_order", order_log[i], exp_order[i]);
        end

        // Response backpressure with port 1 waiting.
        rsp0_rdy = 1'b0;
        exp_bp = alu_ref(ALU_OP_XOR, 32'hF0F0_1234, 32'h0F0F_0000);
        issue(0, ALU_OP_XOR, 32'hF0F0_1234, 32'h0F0F_0000, 1);
        sb1.push_back(alu_ref(ALU_OP_SUB, 32'd50, 32'd8));
        req1_valid = 1'b1; req1_op = ALU_OP_SUB; req1_src1 = 32'd50; req1_src2 = 32'd8;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_rsp0", rsp0_valid, 1);
            check("bp_result", rsp_result, exp_bp.res);
            check("bp_ready0", req0_ready, 0);
            check("bp_ready1", req1_ready, 0);
        end
        @(posedge clk);
        #1;
        rsp0_rdy = 1'b1;
        @(negedge clk);
        check("hs_ready1", req1_ready, 0);
        @(negedge clk);
        check("post_hs_ready1", req1_ready, 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        drain();

        // Reset asserted during EXEC drops the request.
        issue(0, ALU_OP_ADD, 32'h1111, 32'h2222, 0);
        check("pre_rst_src1", alu_src1, 32'h1111);
        rst_n = 1'b0;
        #1;
        check("mid_rst_src1", alu_src1, 0);
        check("mid_rst_src2", alu_src2, 0);
        check("mid_rst_ctrl", alu_control, 0);
        check("mid_rst_result", rsp_result, 0);
        check("mid_rst_less", rsp_less, 0);
        check("mid_rst_zero", rsp_zero, 0);
        check("mid_rst_rsp0", rsp0_valid, 0);
        check("mid_rst_rsp1", rsp1_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_no_rsp0", rsp0_valid, 0);
        @(posedge clk);
        #1;
        issue(0, ALU_OP_SUB, 32'd9, 32'd4, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
